// File: rtl/board_row_fetcher.sv
// Fetches one playfield row per cell-row start during hblank into a shadow buffer,
// swaps it in at the next line start, and renders per-pixel board colour with 2 CLK latency.
module board_row_fetcher #(
    parameter int BOARD_X0 = 240,
    parameter int BOARD_Y0 = 80,
    parameter int CELL_PX  = 16,
    parameter int COLS     = 10,
    parameter int ROWS     = 20,
    parameter int H_FETCH  = 640,
    parameter int V_TOTAL  = 525
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic [11:0] palette0,
    input  logic [11:0] palette1,
    input  logic [11:0] palette2,
    output logic        brd_rd_req,
    output logic [7:0]  brd_rd_addr,
    input  logic        brd_rd_ack,
    input  logic [2:0]  brd_rd_data,
    output logic [11:0] pix_rgb,
    output logic        pix_valid,
    output logic        underrun
);

    localparam int CELL_SH = $clog2(CELL_PX);
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int BOARD_W = COLS * CELL_PX;
    localparam int BOARD_H = ROWS * CELL_PX;

    typedef enum logic [1:0] {IDLE, CLEAR, REQ, DONE} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [7:0]         row_q, row_d;
    logic [7:0]         addr_q, addr_d;
    logic               req_q, req_d;
    logic               pend_q, pend_d;
    logic               under_q, under_d;
    logic               at_fetch_q, at_fetch_d;
    logic               at_zero_q, at_zero_d;
    logic [2:0]         shadow_q [COLS];
    logic [2:0]         shadow_d [COLS];
    logic [2:0]         active_q [COLS];
    logic [2:0]         active_d [COLS];

    logic               vld_p1_q, vld_p1_d;
    logic [2:0]         id_p1_q, id_p1_d;
    logic [11:0]        pal_p1_q, pal_p1_d;
    logic [CELL_SH-1:0] lx_p1_q, lx_p1_d;
    logic [CELL_SH-1:0] ly_p1_q, ly_p1_d;
    logic               vld_p2_q, vld_p2_d;
    logic [11:0]        rgb_p2_q, rgb_p2_d;

    logic [10:0]        next_y, nrel_y, rel_x, rel_y;
    logic [COL_W-1:0]   pcol;
    logic               row_start, trigger, swap, in_board;

    function automatic logic [11:0] pal_sel(input logic [2:0] id, input logic [11:0] p0,
                                            input logic [11:0] p1, input logic [11:0] p2);
        case (id)
            3'd1, 3'd4, 3'd7: pal_sel = p0;
            3'd2, 3'd5:       pal_sel = p1;
            3'd3, 3'd6:       pal_sel = p2;
            default:          pal_sel = 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] cell_rgb(input logic [2:0] id, input logic [CELL_SH-1:0] lx,
                                             input logic [CELL_SH-1:0] ly, input logic [11:0] pal);
        if (id == 3'd0 || lx == CELL_SH'(CELL_PX - 1) || ly == CELL_SH'(CELL_PX - 1))
            cell_rgb = 12'h000;
        else
            cell_rgb = pal;
    endfunction

    // Range tests use wrap-around subtraction: below-origin values become huge and fail "< size".
    always_comb begin
        next_y    = (DrawY == 10'(V_TOTAL - 1)) ? 11'd0 : {1'b0, DrawY} + 11'd1;
        nrel_y    = next_y - 11'(BOARD_Y0);
        row_start = (nrel_y < 11'(BOARD_H)) && (nrel_y[CELL_SH-1:0] == '0);
        trigger   = (DrawX == 10'(H_FETCH)) && !at_fetch_q && row_start;
        swap      = (DrawX == 10'd0) && !at_zero_q && pend_q;

        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        req_d      = req_q;
        pend_d     = pend_q;
        under_d    = under_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        at_fetch_d = (DrawX == 10'(H_FETCH));
        at_zero_d  = (DrawX == 10'd0);

        if (swap) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
            if (state_q == CLEAR || state_q == REQ) begin
                under_d = 1'b1;
                state_d = IDLE;
                req_d   = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: if (trigger) begin
                    state_d = CLEAR;
                    row_d   = 8'(nrel_y >> CELL_SH);
                end
                CLEAR: begin
                    for (int i = 0; i < COLS; i++) shadow_d[i] = 3'd0;
                    pend_d  = 1'b1;
                    col_d   = '0;
                    req_d   = 1'b1;
                    addr_d  = 8'(row_q * COLS);
                    state_d = REQ;
                end
                REQ: if (brd_rd_ack) begin
                    shadow_d[col_q] = brd_rd_data;
                    if (col_q == COL_W'(COLS - 1)) begin
                        req_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        col_d  = col_q + 1'b1;
                        addr_d = addr_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // S1: board hit test, cell lookup and palette sample
    always_comb begin
        rel_x    = {1'b0, DrawX} - 11'(BOARD_X0);
        rel_y    = {1'b0, DrawY} - 11'(BOARD_Y0);
        pcol     = COL_W'(rel_x >> CELL_SH);
        in_board = blank && (rel_x < 11'(BOARD_W)) && (rel_y < 11'(BOARD_H));
        vld_p1_d = in_board;
        id_p1_d  = in_board ? active_q[pcol] : 3'd0;
        pal_p1_d = pal_sel(id_p1_d, palette0, palette1, palette2);
        lx_p1_d  = DrawX[CELL_SH-1:0];
        ly_p1_d  = DrawY[CELL_SH-1:0];
    end

    // S2: final colour with outline and off-board blanking
    always_comb begin
        vld_p2_d = vld_p1_q;
        rgb_p2_d = vld_p1_q ? cell_rgb(id_p1_q, lx_p1_q, ly_p1_q, pal_p1_q) : 12'h000;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            under_q    <= 1'b0;
            at_fetch_q <= 1'b0;
            at_zero_q  <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                shadow_q[i] <= 3'd0;
                active_q[i] <= 3'd0;
            end
            vld_p1_q   <= 1'b0;
            id_p1_q    <= 3'd0;
            pal_p1_q   <= 12'h000;
            lx_p1_q    <= '0;
            ly_p1_q    <= '0;
            vld_p2_q   <= 1'b0;
            rgb_p2_q   <= 12'h000;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            under_q    <= under_d;
            at_fetch_q <= at_fetch_d;
            at_zero_q  <= at_zero_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            vld_p1_q   <= vld_p1_d;
            id_p1_q    <= id_p1_d;
            pal_p1_q   <= pal_p1_d;
            lx_p1_q    <= lx_p1_d;
            ly_p1_q    <= ly_p1_d;
            vld_p2_q   <= vld_p2_d;
            rgb_p2_q   <= rgb_p2_d;
        end
    end

    assign brd_rd_req  = req_q;
    assign brd_rd_addr = addr_q;
    assign pix_rgb     = rgb_p2_q;
    assign pix_valid   = vld_p2_q;
    assign underrun    = under_q;

endmodule

// File: tb/tb_board_row_fetcher.sv
// Directed bench for board_row_fetcher: default-geometry instance plus a BOARD_Y0 = 0 instance for frame wrap.
module tb_board_row_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [11:0] pal0, pal1, pal2;

    logic        req_a, req_b;
    logic [7:0]  addr_a, addr_b;
    logic        ack_a = 1'b0, ack_b = 1'b0;
    logic [2:0]  data_a = 3'd0, data_b = 3'd0;
    logic [11:0] rgb_a, rgb_b;
    logic        vld_a, vld_b, und_a, und_b;

    logic [2:0]  mem [256];
    int          dly_a = 1;
    int          cnt_a = 0, cnt_b = 0;
    int          log_a[$], log_b[$];
    int          n_chk = 0, n_pass = 0;

    int          r0 [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int          r1 [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    logic [11:0] exp0 [10] = '{12'hF00, 12'h0F0, 12'h00F, 12'hF00, 12'h0F0,
                               12'h00F, 12'hF00, 12'h000, 12'hF00, 12'h0F0};
    logic [11:0] exp1 [10] = '{12'hF00, 12'h00F, 12'h0F0, 12'hF00, 12'h00F,
                               12'h0F0, 12'hF00, 12'h000, 12'hF00, 12'h00F};

    always #10 clk = ~clk;

    board_row_fetcher dut_a (
        .CLK(clk), .RESET(rst_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .palette0(pal0), .palette1(pal1), .palette2(pal2),
        .brd_rd_req(req_a), .brd_rd_addr(addr_a), .brd_rd_ack(ack_a), .brd_rd_data(data_a),
        .pix_rgb(rgb_a), .pix_valid(vld_a), .underrun(und_a)
    );

    board_row_fetcher #(.BOARD_Y0(0)) dut_b (
        .CLK(clk), .RESET(rst_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .palette0(pal0), .palette1(pal1), .palette2(pal2),
        .brd_rd_req(req_b), .brd_rd_addr(addr_b), .brd_rd_ack(ack_b), .brd_rd_data(data_b),
        .pix_rgb(rgb_b), .pix_valid(vld_b), .underrun(und_b)
    );

    // Board RAM responders: ack after a programmable number of CLKs with req high.
    always @(negedge clk) begin
        if (!req_a || ack_a) begin
            ack_a = 1'b0;
            cnt_a = 0;
        end else begin
            cnt_a++;
            if (cnt_a >= dly_a) begin
                ack_a  = 1'b1;
                data_a = mem[addr_a];
                log_a.push_back(int'(addr_a));
            end
        end
    end

    always @(negedge clk) begin
        if (!req_b || ack_b) begin
            ack_b = 1'b0;
            cnt_b = 0;
        end else begin
            cnt_b++;
            ack_b  = 1'b1;
            data_b = mem[addr_b];
            log_b.push_back(int'(addr_b));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input int x, input int y,
                       input logic [11:0] e_rgb, input logic e_vld);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick(2);
        chk({tag, "_rgb"}, 32'(rgb_a), 32'(e_rgb));
        chk({tag, "_vld"}, 32'(vld_a), 32'(e_vld));
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 3'd0;
        for (int i = 0; i < 10; i++) begin
            mem[i]      = 3'(r0[i]);
            mem[10 + i] = 3'(r1[i]);
        end
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
        pal0 = 12'hF00; pal1 = 12'h0F0; pal2 = 12'h00F;
        tick(3);
        chk("rst_req", 32'(req_a), 0);
        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_rgb", 32'(rgb_a), 0);
        chk("rst_vld", 32'(vld_a), 0);
        chk("rst_und", 32'(und_a), 0);
        rst_n = 1'b1;
        tick(2);

        // Row 0 fetch on line 79 hblank, shown on line 80
        DrawY = 10'd79; DrawX = 10'd640;
        tick(30);
        chk("r0_naddr", 32'(log_a.size()), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("r0_addr%0d", i), 32'(qget(log_a, i)), 32'(i));
        chk("r0_req_idle", 32'(req_a), 0);
        DrawY = 10'd80; DrawX = 10'd0;
        tick(1);
        blank = 1'b1; DrawX = 10'd240;
        tick(1);
        chk("lat_1clk_vld", 32'(vld_a), 0);
        tick(1);
        chk("lat_2clk_rgb", 32'(rgb_a), 32'h00F00);
        chk("lat_2clk_vld", 32'(vld_a), 1);
        for (int i = 0; i < 10; i++) pix($sformatf("r0_c%0d", i), 243 + 16 * i, 80, exp0[i], 1'b1);
        pix("outl_x", 255, 80, 12'h000, 1'b1);
        pix("outl_y", 247, 95, 12'h000, 1'b1);
        pix("left_edge", 239, 80, 12'h000, 1'b0);
        pix("right_edge", 400, 80, 12'h000, 1'b0);
        blank = 1'b0;
        pix("blank0", 243, 80, 12'h000, 1'b0);
        blank = 1'b1;

        // Non-boundary lines fetch nothing; line 95 fetches row 1
        log_a.delete();
        for (int y = 80; y <= 94; y++) begin
            DrawY = 10'(y); DrawX = 10'd640;
            tick(3);
            DrawX = 10'd0;
            tick(2);
        end
        chk("nonbnd_nreq", 32'(log_a.size()), 0);
        pix("nonbnd_pix", 259, 90, 12'h0F0, 1'b1);
        DrawY = 10'd95; DrawX = 10'd640;
        tick(30);
        chk("r1_naddr", 32'(log_a.size()), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("r1_addr%0d", i), 32'(qget(log_a, i)), 32'(10 + i));
        DrawY = 10'd96; DrawX = 10'd0;
        tick(1);
        for (int i = 0; i < 10; i += 3) pix($sformatf("r1_c%0d", i), 243 + 16 * i, 96, exp1[i], 1'b1);
        pix("r1_c7", 355, 100, exp1[7], 1'b1);
        pix("r1_outl_y", 243, 111, 12'h000, 1'b1);

        // Underrun: 41 CLK per read, swap lands after cells 0..3
        log_a.delete();
        dly_a = 40;
        DrawY = 10'd79; DrawX = 10'd640;
        tick(179);
        chk("ur_pre_req", 32'(req_a), 1);
        chk("ur_pre_und", 32'(und_a), 0);
        DrawX = 10'd0; DrawY = 10'd80;
        tick(1);
        chk("ur_und", 32'(und_a), 1);
        chk("ur_req_drop", 32'(req_a), 0);
        chk("ur_nacks", 32'(log_a.size()), 4);
        pix("ur_c0", 243, 80, 12'hF00, 1'b1);
        pix("ur_c3", 291, 80, 12'hF00, 1'b1);
        pix("ur_c4", 307, 80, 12'h000, 1'b1);
        pix("ur_c9", 387, 80, 12'h000, 1'b1);
        DrawY = 10'd524; DrawX = 10'd640;
        tick(3);
        DrawY = 10'd0; DrawX = 10'd0;
        tick(3);
        chk("ur_sticky_frame", 32'(und_a), 1);
        dly_a = 1;
        log_a.delete();
        DrawY = 10'd79; DrawX = 10'd640;
        tick(30);
        DrawY = 10'd80; DrawX = 10'd0;
        tick(1);
        chk("ur_sticky_refetch", 32'(und_a), 1);
        chk("refetch_naddr", 32'(log_a.size()), 10);
        pix("refetch_c4", 307, 80, 12'h0F0, 1'b1);

        // Palette change reaches output 2 CLK after the next sample
        pix("pal_old", 259, 80, 12'h0F0, 1'b1);
        pal1 = 12'hABC;
        tick(1);
        chk("pal_1clk", 32'(rgb_a), 32'h0F0);
        tick(1);
        chk("pal_2clk", 32'(rgb_a), 32'hABC);

        // Async reset in the middle of a row-1 read
        dly_a = 40;
        DrawY = 10'd95; DrawX = 10'd640;
        tick(10);
        chk("mid_req", 32'(req_a), 1);
        chk("mid_addr", 32'(addr_a), 10);
        DrawY = 10'd96; DrawX = 10'd259;
        tick(2);
        chk("mid_rgb", 32'(rgb_a), 32'hABC);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(req_a), 0);
        chk("arst_addr", 32'(addr_a), 0);
        chk("arst_rgb", 32'(rgb_a), 0);
        chk("arst_vld", 32'(vld_a), 0);
        chk("arst_und", 32'(und_a), 0);
        tick(2);
        rst_n = 1'b1;
        dly_a = 1;
        tick(1);
        pix("post_rst_c0", 243, 80, 12'h000, 1'b1);
        chk("post_rst_req", 32'(req_a), 0);

        // Frame wrap on the BOARD_Y0 = 0 instance
        log_a.delete();
        log_b.delete();
        DrawY = 10'd524; DrawX = 10'd640;
        tick(30);
        chk("wrap_naddr", 32'(log_b.size()), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("wrap_addr%0d", i), 32'(qget(log_b, i)), 32'(i));
        chk("wrap_a_noreq", 32'(log_a.size()), 0);
        DrawY = 10'd0; DrawX = 10'd0;
        tick(1);
        DrawX = 10'd243;
        tick(2);
        chk("wrap_c0_rgb", 32'(rgb_b), 32'hF00);
        chk("wrap_c0_vld", 32'(vld_b), 1);
        chk("wrap_a_vld", 32'(vld_a), 0);
        DrawX = 10'd259;
        tick(2);
        chk("wrap_c1_rgb", 32'(rgb_b), 32'hABC);
        chk("wrap_und", 32'(und_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
